// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port between the byte source,
// the loader and the instruction memory.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              last_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;

  modport master (
    output byte_valid_i, byte_data_i, last_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i, last_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: zero-fills the memory, packs a little-endian
// byte stream into 32-bit words written from address 0, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  imem_loader_if.slave      bus,
  output logic              busy_o,
  output logic              start_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic              last_seen_q, last_seen_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              accept_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    last_seen_d = last_seen_q;
    count_d     = count_q;
    err_d       = err_q;
    accept_s    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_i) begin
          state_d = S_CLEAR;
          ptr_d   = {ADDR_W{1'b0}};
          count_d = {(ADDR_W+1){1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d     = S_RECV;
          ptr_d       = {ADDR_W{1'b0}};
          idx_d       = 2'd0;
          asm_d       = 32'd0;
          last_seen_d = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_ONE;
        end
      end
      S_RECV: begin
        accept_s = bus.byte_valid_i & byte_ready_q;
        if (accept_s) begin
          // Each new word starts from zero so a short final word has clean upper bytes
          case (idx_q)
            2'd0:    asm_d = {24'd0, bus.byte_data_i};
            2'd1:    asm_d = {16'd0, bus.byte_data_i, asm_q[7:0]};
            2'd2:    asm_d = {8'd0, bus.byte_data_i, asm_q[15:0]};
            2'd3:    asm_d = {bus.byte_data_i, asm_q[23:0]};
            default: asm_d = 32'd0;
          endcase
          idx_d = idx_q + 2'd1;
          if ((idx_q == 2'd3) || bus.last_i) begin
            state_d     = S_WRITE;
            last_seen_d = bus.last_i;
            if (bus.last_i && (idx_q != 2'd3)) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + ADDR_ONE;
        count_d = count_q + CNT_ONE;
        idx_d   = 2'd0;
        if (last_seen_q) begin
          state_d = S_DONE;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_RECV;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    byte_ready_d = (state_d == S_RECV);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_RECV) || (state_d == S_WRITE);
    start_d      = (state_d == S_DONE);
    mem_we_d     = (state_d == S_CLEAR) || (state_d == S_WRITE);
    if (state_d == S_WRITE) begin
      mem_addr_d = ptr_d;
      mem_data_d = asm_d;
    end else if (state_d == S_CLEAR) begin
      mem_addr_d = ptr_d;
      mem_data_d = 32'd0;
    end else begin
      mem_addr_d = {ADDR_W{1'b0}};
      mem_data_d = 32'd0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= {ADDR_W{1'b0}};
      idx_q        <= 2'd0;
      asm_q        <= 32'd0;
      last_seen_q  <= 1'b0;
      count_q      <= {(ADDR_W+1){1'b0}};
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_data_q   <= 32'd0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      last_seen_q  <= last_seen_d;
      count_q      <= count_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
    end
  end

  assign bus.byte_ready_o = byte_ready_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign busy_o           = busy_q;
  assign start_o          = start_q;
  assign word_count_o     = count_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader; a byte-queue image model predicts every
// write, the final status and the whole memory image.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       busy;
  logic       start;
  logic [8:0] word_count;
  logic       err;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [7:0]  img_q[$];
  logic [31:0] tb_mem [0:255];

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .bus(bus),
    .busy_o(busy), .start_o(start), .word_count_o(word_count), .err_o(err)
  );

  always #5 clk = ~clk;

  // Instruction memory modelled as a plain array written through the write port
  always @(posedge clk) begin
    if (bus.mem_we_o) tb_mem[bus.mem_addr_o] <= bus.mem_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Little-endian word wi of the image, using only the first avail bytes
  function automatic logic [31:0] model_word(input int wi, input int avail);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (4 * wi + j < avail) w = w | (32'(img_q[4 * wi + j]) << (8 * j));
    end
    return w;
  endfunction

  task automatic check_image(input int n_bytes);
    int nw;
    int bad;
    logic [31:0] exp;
    nw = (n_bytes + 3) / 4;
    if (nw > 256) nw = 256;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      exp = (a < nw) ? model_word(a, n_bytes) : 32'd0;
      if (tb_mem[a] !== exp) bad++;
    end
    chk("mem_image_bad_words", 64'(bad), 64'd0);
  endtask

  task automatic load_and_clear();
    int bad;
    logic [7:0] a8;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("clear_first_status", {61'd0, start, err, |word_count}, 64'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a8 = 8'(i);
      if ({bus.mem_we_o, busy, bus.byte_ready_o, bus.mem_addr_o, bus.mem_data_o} !==
          {1'b1, 1'b1, 1'b0, a8, 32'd0}) bad++;
      tick();
    end
    chk("clear_sweep_bad_cycles", 64'(bad), 64'd0);
    chk("recv_entry", {61'd0, bus.byte_ready_o, busy, bus.mem_we_o}, {61'd0, 3'b110});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int waited;
    bus.byte_valid_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.last_i      = 1'($urandom_range(0, 1));
      bus.byte_data_i = 8'($urandom);
      tick();
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = d;
    bus.last_i       = l;
    waited = 0;
    while (!bus.byte_ready_o && waited < 64) begin
      tick();
      waited++;
    end
    chk("byte_ready_before_accept", {63'd0, bus.byte_ready_o}, 64'd1);
    tick();
    bus.byte_valid_i = 1'b0;
    bus.last_i       = 1'b0;
  endtask

  task automatic run_stream(input bit with_last, input int gmin, input int gmax);
    int n;
    int wi;
    int nw;
    logic l;
    n = img_q.size();
    for (int k = 0; k < n; k++) begin
      l = with_last && (k == n - 1);
      send_byte(img_q[k], l, $urandom_range(gmin, gmax));
      if ((k % 4 == 3) || l) begin
        wi = k / 4;
        chk("write_port", {bus.mem_we_o, 23'd0, bus.mem_addr_o, bus.mem_data_o},
            {1'b1, 23'd0, 8'(wi), model_word(wi, k + 1)});
      end
    end
    tick();
    nw = (n + 3) / 4;
    if (nw > 256) nw = 256;
    chk("done_status", {60'd0, start, busy, bus.byte_ready_o, bus.mem_we_o}, {60'd0, 4'b1000});
    chk("word_count", {55'd0, word_count}, 64'(nw));
    chk("err", {63'd0, err}, {63'd0, (with_last ? (n % 4 != 0) : 1'b1)});
    check_image(n);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h5a;
    bus.last_i       = 1'b0;
    tick();
    chk("reset_outputs", {bus.byte_ready_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o,
                          busy, start, word_count, err}, 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_ready", {62'd0, bus.byte_ready_o, busy}, 64'd0);
    bus.byte_valid_i = 1'b0;

    // Fixed program image with 2-cycle valid gaps
    load_and_clear();
    img_q = {8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
    run_stream(1'b1, 2, 2);
    chk("fixed_word0", {32'd0, tb_mem[0]}, 64'h0000_0000_0050_0513);
    chk("fixed_word1", {32'd0, tb_mem[1]}, 64'h0000_0000_0060_0593);

    // Reload from DONE with a partial final word
    load_and_clear();
    img_q = {8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h11, 8'h22};
    run_stream(1'b1, 0, 0);
    chk("partial_word0", {32'd0, tb_mem[0]}, 64'h0000_0000_ddcc_bbaa);
    chk("partial_word1", {32'd0, tb_mem[1]}, 64'h0000_0000_0000_2211);

    // Random images with random backpressure
    for (int r = 0; r < 3; r++) begin
      load_and_clear();
      img_q.delete();
      for (int b = 0, n = $urandom_range(1, 40); b < n; b++) img_q.push_back(8'($urandom));
      run_stream(1'b1, 0, 3);
    end

    // Overflow: 1024 bytes and no last marker
    load_and_clear();
    img_q.delete();
    for (int b = 0; b < 1024; b++) img_q.push_back(8'($urandom));
    run_stream(1'b0, 0, 0);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h77;
    repeat (3) tick();
    chk("overflow_byte_refused", {60'd0, bus.byte_ready_o, bus.mem_we_o, start, err},
        {60'd0, 4'b0011});
    chk("overflow_count_hold", {55'd0, word_count}, 64'd256);
    bus.byte_valid_i = 1'b0;

    // Reset in the middle of a word
    load_and_clear();
    img_q = {8'h01, 8'h02};
    send_byte(img_q[0], 1'b0, 0);
    send_byte(img_q[1], 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_outputs", {bus.byte_ready_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o,
                              busy, start, word_count, err}, 64'd0);
    tick();
    chk("mid_reset_stays_idle", {62'd0, busy, bus.byte_ready_o}, 64'd0);
    load_and_clear();
    check_image(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
